instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//   Fetch stage directly upstream of the synchronous instruction memory.
//   - Owns the PC and drives the memory word address.
//   - Tracks the one-cycle read latency, captures the returned word, and hands {pc, inst} to decode over valid/ready.
//   - A 2-entry output buffer absorbs decode back-pressure without losing in-flight reads.
//   - A redirect (branch/jump) flushes everything younger and restarts fetch.
// PARAMETERS
//   ADDR_W    16         word-address width (PC counts 32-bit words, not bytes)
//   DATA_W    32         instruction width
//   RESET_PC  16'h0000   first word address fetched after reset
// PORTS
//   clk             in   1       clock; all state updates on posedge
//   rst_n           in   1       asynchronous, active-low reset
//   imem_addr       out  ADDR_W  word address to instruction memory (combinational from state)
//   imem_rd         in   DATA_W  memory read data; valid the cycle after its address was presented
//   redirect_valid  in   1       restart fetch at redirect_pc this cycle
//   redirect_pc     in   ADDR_W  new word address
//   out_valid       out  1       {out_pc, out_inst} valid toward decode
//   out_ready       in   1       decode accepts; transfer = out_valid & out_ready
//   out_inst        out  DATA_W  fetched instruction (buffer head)
//   out_pc          out  ADDR_W  word address of out_inst
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - fetch_pc=RESET_PC, inflight=0, buffer count=0.
//     - out_valid=0, out_inst=0, out_pc=0, imem_addr=RESET_PC.
//   State:
//     - fetch_pc: next address to issue.
//     - inflight bit plus inflight_pc: a read issued last cycle whose data is on imem_rd now.
//     - FIFO of depth 2 holding {pc, inst}.
//   Issue rule, normal cycle:
//     - pop = out_valid & out_ready.
//     - issue = (count + inflight - pop) < 2.
//     - imem_addr = fetch_pc.
//     - On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1. Otherwise inflight<=0.
//     - When not issuing, imem_addr still shows fetch_pc; the memory result is ignored.
//   Capture:
//     - If inflight=1 and not redirecting, push {inflight_pc, imem_rd} into the FIFO at this posedge.
//     - The issue rule guarantees no overflow.
//   Latency and throughput:
//     - Address issued in cycle N produces out_valid with that pc in cycle N+2.
//     - Steady state with out_ready=1 is 1 instruction/cycle, in consecutive pc order.
//   Handshake:
//     - While out_valid=1 & out_ready=0, out_valid/out_pc/out_inst hold stable.
//     - out_valid never drops without a transfer, except on redirect.
//   Redirect (priority over everything):
//     - imem_addr=redirect_pc combinationally in that cycle.
//     - At posedge: FIFO cleared (count=0), inflight<=1, inflight_pc<=redirect_pc, fetch_pc<=redirect_pc+1.
//     - The stale imem_rd arriving in the redirect cycle is discarded.
//     - out_valid=0 in cycle R+1; out_valid=1 with out_pc=redirect_pc in cycle R+2.
//     - A transfer handshaked in the redirect cycle itself counts as delivered; all other entries are dropped.
//     - Back-to-back redirects: the last one wins; each restarts the 2-cycle latency.
//   Arithmetic:
//     - PC increment is modulo 2^ADDR_W: 16'hFFFF+1 -> 16'h0000, no flag.
//   Reset mid-operation:
//     - Immediate return to reset values.
//     - Buffered and in-flight words are lost.
//     - Fetch restarts at RESET_PC on the first edge after rst_n=1.
// TESTING
//   1. Reset release, out_ready=1, mem[i]=32'hA000_0000+i -> out_valid first at cycle 2; out_pc 0,1,2,3..., out_inst A0000000,A0000001... every cycle.
//   2. out_ready=0 for 5 cycles mid-stream -> count saturates at 2, issue stops, head held stable; on release, pcs continue with no gap and no duplicate.
//   3. redirect_valid=1, redirect_pc=16'h0040 while 2 entries are buffered -> out_valid=0 in the next cycle, then out_pc=0040, 0041...; no old pc ever appears.
//   4. Redirect together with out_valid&out_ready -> head counted delivered once; next delivered pc=redirect_pc.
//   5. redirect_pc=16'hFFFE, out_ready=1 -> out_pc sequence FFFE, FFFF, 0000, 0001.
//   6. rst_n pulsed low mid-stream with out_ready=0 -> out_valid=0 asynchronously; after release, first out_pc=RESET_PC at cycle 2.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage in front of a one-cycle-latency instruction memory: owns the PC,
// tracks the in-flight read and buffers {pc, inst} for decode in a 2-entry FIFO.
module instruction_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic              r_head;
  logic [ADDR_W-1:0] r_pc   [2];
  logic [DATA_W-1:0] r_inst [2];

  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_tail;
  logic [2:0] w_occ;

  assign out_valid = (r_count != 2'd0);
  assign out_pc    = out_valid ? r_pc[r_head]   : '0;
  assign out_inst  = out_valid ? r_inst[r_head] : '0;

  assign w_pop   = out_valid & out_ready;
  // Buffered + in-flight words after this cycle's pop must leave room for one more.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (w_occ < 3'd2);
  assign w_push  = r_inflight & ~redirect_valid;
  // The issue rule keeps pushes to count 0 or 1, so the tail is head or head+1.
  assign w_tail  = r_head ^ r_count[0];

  assign imem_addr = redirect_valid ? redirect_pc : r_fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_count       <= 2'd0;
      r_head        <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= redirect_pc + ADDR_W'(1);
      r_inflight_pc <= redirect_pc;
      r_inflight    <= 1'b1;
      r_count       <= 2'd0;
    end else begin
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(1);
        r_inflight_pc <= r_fetch_pc;
        r_inflight    <= 1'b1;
      end else begin
        r_inflight    <= 1'b0;
      end
      r_head  <= r_head ^ w_pop;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[w_tail]   <= r_inflight_pc;
      r_inst[w_tail] <= imem_rd;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural synchronous memory
// whose word at address a is 32'hA000_0000 + a.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [15:0] out_pc;

  int n_tot = 0;
  int n_bad = 0;

  instruction_fetch #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd        (imem_rd),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rd <= 32'hA000_0000 + {16'h0000, imem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic rv, input logic [15:0] rpc);
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
  endtask

  task automatic expv(input string tag, input logic [15:0] pc);
    chk({tag, "_v"},    {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"},   {16'd0, out_pc},    {16'd0, pc});
    chk({tag, "_inst"}, out_inst,           32'hA000_0000 + {16'd0, pc});
  endtask

  task automatic expnv(input string tag);
    chk({tag, "_nv"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] p;
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;

    // reset state
    @(negedge clk);
    expnv("rst");
    chk("rst_pc",   {16'd0, out_pc},    32'd0);
    chk("rst_inst", out_inst,           32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    adv();
    rst_n = 1'b1;

    // 1: start-up latency and streaming
    set_in(1'b1, 1'b0, 16'h0); expnv("t1c0"); chk("t1c0_addr", {16'd0, imem_addr}, 32'd0); adv();
    set_in(1'b1, 1'b0, 16'h0); expnv("t1c1"); chk("t1c1_addr", {16'd0, imem_addr}, 32'd1); adv();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, 16'h0); expv("t1", 16'(i)); adv();
    end

    // 2: back-pressure holds head, issue stops at addr 8
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0, 16'h0); expv("t2hold", 16'd6);
      chk("t2_addr", {16'd0, imem_addr}, 32'd8); adv();
    end
    for (int i = 6; i < 10; i++) begin
      set_in(1'b1, 1'b0, 16'h0); expv("t2rel", 16'(i)); adv();
    end

    // 3: redirect with two buffered entries
    set_in(1'b0, 1'b0, 16'h0); expv("t3fill", 16'd10); adv();
    set_in(1'b0, 1'b0, 16'h0); expv("t3fill", 16'd10); adv();
    set_in(1'b0, 1'b1, 16'h0040); expv("t3r", 16'd10);
    chk("t3_raddr", {16'd0, imem_addr}, 32'h40); adv();
    set_in(1'b1, 1'b0, 16'h0); expnv("t3gap"); adv();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 16'h0); expv("t3new", 16'h0040 + 16'(i)); adv();
    end

    // 4: redirect coincident with a transfer
    set_in(1'b1, 1'b1, 16'h0080); expv("t4head", 16'h0043); adv();
    set_in(1'b1, 1'b0, 16'h0); expnv("t4gap"); adv();
    set_in(1'b1, 1'b0, 16'h0); expv("t4new", 16'h0080); adv();
    set_in(1'b1, 1'b0, 16'h0); expv("t4new", 16'h0081); adv();

    // 5: PC wrap
    set_in(1'b1, 1'b1, 16'hFFFE); expv("t5head", 16'h0082); adv();
    set_in(1'b1, 1'b0, 16'h0); expnv("t5gap"); adv();
    p = 16'hFFFE;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 16'h0); expv("t5wrap", p); p = p + 16'd1; adv();
    end

    // back-to-back redirects: last one wins
    set_in(1'b1, 1'b1, 16'h0100); expv("bbhead", 16'h0002); adv();
    set_in(1'b1, 1'b1, 16'h0200); expnv("bb1"); adv();
    set_in(1'b1, 1'b0, 16'h0); expnv("bb2"); adv();
    set_in(1'b1, 1'b0, 16'h0); expv("bbnew", 16'h0200); adv();
    set_in(1'b1, 1'b0, 16'h0); expv("bbnew", 16'h0201); adv();

    // 6: async reset mid-stream with stalled output
    set_in(1'b0, 1'b0, 16'h0); expv("t6fill", 16'h0202); adv();
    set_in(1'b0, 1'b0, 16'h0); expv("t6fill", 16'h0202); adv();
    set_in(1'b0, 1'b0, 16'h0);
    rst_n = 1'b0;
    #1;
    expnv("t6async");
    chk("t6_pc",   {16'd0, out_pc},    32'd0);
    chk("t6_inst", out_inst,           32'd0);
    chk("t6_addr", {16'd0, imem_addr}, 32'd0);
    adv();
    adv();
    rst_n = 1'b1;
    set_in(1'b1, 1'b0, 16'h0); expnv("t6c0"); adv();
    set_in(1'b1, 1'b0, 16'h0); expnv("t6c1"); adv();
    set_in(1'b1, 1'b0, 16'h0); expv("t6c2", 16'h0000); adv();
    set_in(1'b1, 1'b0, 16'h0); expv("t6c3", 16'h0001); adv();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
